// File: rtl/spi_rx_pkg.sv
// Shared definitions for the SPI slave lane receiver: FSM state encodings
// and the position of the per-beat flag bits stored alongside beat data.
package spi_rx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RX    = 2'd1,
        FLUSH = 2'd2
    } rx_state_e;

    // Flag bits sit directly above the beat data in each FIFO entry.
    localparam int FLAG_LAST  = 0;
    localparam int FLAG_ABORT = 1;
    localparam int NUM_FLAGS  = 2;

    // Assemble the flag field for a beat.
    function automatic logic [NUM_FLAGS-1:0] mk_flags(input logic last, input logic abort);
        logic [NUM_FLAGS-1:0] f;
        f             = '0;
        f[FLAG_LAST]  = last;
        f[FLAG_ABORT] = abort;
        return f;
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO. The head entry is visible on
// rd_data_o whenever empty_o is low; a read while full frees room for a
// write in the same clock. DEPTH must be a power of two.
module sync_fifo_fwft #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_rd;
    logic             do_wr;

    assign full_o    = (count_q == (AW+1)'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign do_rd     = rd_en_i && !empty_o;
    assign do_wr     = wr_en_i && (!full_o || do_rd);
    assign rd_data_o = mem_q[rd_ptr_q];

    // Storage array: written only, no reset, so it maps onto RAM.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_rd) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/spi_slave_rx_lanes.sv
// SPI slave receiver: synchronises the SPI pins into clk, deframes
// FEATURE_LENGTH words per CS-low window and streams them out as
// LANES-wide beats through a small FWFT FIFO with last/abort flags.
module spi_slave_rx_lanes
    import spi_rx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned FEATURE_LENGTH = 300,
    parameter int unsigned LANES          = 8,
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned CPOL           = 0,
    parameter int unsigned CPHA           = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          sclk,
    input  logic                          mosi,
    input  logic                          cs,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic [LANES*DATA_WIDTH-1:0]   o_data,
    output logic                          o_last,
    output logic                          o_abort,
    output logic                          o_overflow,
    output logic                          o_busy
);

    localparam int unsigned BEAT_W      = LANES * DATA_WIDTH;
    localparam int unsigned ENTRY_W     = BEAT_W + NUM_FLAGS;
    localparam int unsigned BCW         = $clog2(DATA_WIDTH);
    localparam int unsigned LCW         = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int unsigned WCW         = $clog2(FEATURE_LENGTH + 1);
    localparam logic        SCLK_IDLE   = (CPOL != 0);
    localparam bit          SAMPLE_RISE = (CPOL == CPHA);

    // Synchroniser chain
    logic sclk_meta_q, sclk_sync_q, sclk_dly_q;
    logic cs_meta_q, cs_sync_q;
    logic mosi_meta_q, mosi_sync_q;
    logic sample_edge;

    // Deframer state
    rx_state_e             state_q;
    logic [DATA_WIDTH-2:0] shift_q;
    logic [BCW-1:0]        bit_cnt_q;
    logic [LCW-1:0]        lane_cnt_q;
    logic [WCW-1:0]        word_cnt_q;
    logic [DATA_WIDTH-1:0] lanes_q [LANES];
    logic [ENTRY_W-1:0]    beat_q;
    logic                  push_q;
    logic                  overflow_q;

    logic [DATA_WIDTH-1:0] new_word;
    logic [BEAT_W-1:0]     fill_beat;
    logic [BEAT_W-1:0]     part_beat;
    logic                  word_done;
    logic                  final_word;

    // FIFO side
    logic [ENTRY_W-1:0]    fifo_rd_data;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_rd;

    // Two-flop synchronisers plus a delay flop on sclk for edge detection;
    // reset to idle levels so no spurious edge or CS assertion is seen.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_meta_q <= SCLK_IDLE;
            sclk_sync_q <= SCLK_IDLE;
            sclk_dly_q  <= SCLK_IDLE;
            cs_meta_q   <= 1'b1;
            cs_sync_q   <= 1'b1;
            mosi_meta_q <= 1'b0;
            mosi_sync_q <= 1'b0;
        end else begin
            sclk_meta_q <= sclk;
            sclk_sync_q <= sclk_meta_q;
            sclk_dly_q  <= sclk_sync_q;
            cs_meta_q   <= cs;
            cs_sync_q   <= cs_meta_q;
            mosi_meta_q <= mosi;
            mosi_sync_q <= mosi_meta_q;
        end
    end

    assign sample_edge = SAMPLE_RISE ? ( sclk_sync_q && !sclk_dly_q)
                                     : (!sclk_sync_q &&  sclk_dly_q);

    assign new_word   = {shift_q, mosi_sync_q};
    assign word_done  = sample_edge && (bit_cnt_q == BCW'(DATA_WIDTH - 1));
    assign final_word = word_done && (word_cnt_q == WCW'(FEATURE_LENGTH - 1));

    // fill_beat: current lanes with the just-completed word dropped into
    // its slot; part_beat: current lanes only (for an aborted frame).
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign fill_beat[gi*DATA_WIDTH +: DATA_WIDTH] =
                (lane_cnt_q == LCW'(gi)) ? new_word : lanes_q[gi];
            assign part_beat[gi*DATA_WIDTH +: DATA_WIDTH] = lanes_q[gi];
        end
    endgenerate

    // Deframing FSM: shifts bits, collects words into lanes and stages
    // beats (with flags) for the FIFO one clock later via push_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            lane_cnt_q <= '0;
            word_cnt_q <= '0;
            beat_q     <= '0;
            push_q     <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                lanes_q[i] <= '0;
            end
        end else begin
            push_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!cs_sync_q) begin
                        state_q    <= RX;
                        shift_q    <= '0;
                        bit_cnt_q  <= '0;
                        lane_cnt_q <= '0;
                        word_cnt_q <= '0;
                        for (int i = 0; i < LANES; i++) begin
                            lanes_q[i] <= '0;
                        end
                    end
                end
                RX: begin
                    if (final_word) begin
                        // Final word wins even if CS rises in the same clock.
                        beat_q     <= {mk_flags(1'b1, 1'b0), fill_beat};
                        push_q     <= 1'b1;
                        word_cnt_q <= word_cnt_q + 1'b1;
                        bit_cnt_q  <= '0;
                        lane_cnt_q <= '0;
                        for (int i = 0; i < LANES; i++) begin
                            lanes_q[i] <= '0;
                        end
                        state_q    <= FLUSH;
                    end else if (cs_sync_q) begin
                        if (word_cnt_q == '0) begin
                            state_q <= IDLE;
                        end else begin
                            // Short frame: flush partial lanes, drop partial bits.
                            beat_q     <= {mk_flags(1'b1, 1'b1), part_beat};
                            push_q     <= 1'b1;
                            bit_cnt_q  <= '0;
                            lane_cnt_q <= '0;
                            for (int i = 0; i < LANES; i++) begin
                                lanes_q[i] <= '0;
                            end
                            state_q    <= FLUSH;
                        end
                    end else if (word_done) begin
                        bit_cnt_q  <= '0;
                        word_cnt_q <= word_cnt_q + 1'b1;
                        if (lane_cnt_q == LCW'(LANES - 1)) begin
                            beat_q     <= {mk_flags(1'b0, 1'b0), fill_beat};
                            push_q     <= 1'b1;
                            lane_cnt_q <= '0;
                            for (int i = 0; i < LANES; i++) begin
                                lanes_q[i] <= '0;
                            end
                        end else begin
                            lanes_q[lane_cnt_q] <= new_word;
                            lane_cnt_q          <= lane_cnt_q + 1'b1;
                        end
                    end else if (sample_edge) begin
                        shift_q   <= new_word[DATA_WIDTH-2:0];
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                    end
                end
                FLUSH: begin
                    if (cs_sync_q) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign fifo_rd = i_ready && !fifo_empty;

    sync_fifo_fwft #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (push_q),
        .wr_data_i (beat_q),
        .rd_en_i   (i_ready),
        .rd_data_o (fifo_rd_data),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    // One-clock pulse whenever a staged beat finds the FIFO full.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= push_q && fifo_full && !fifo_rd;
        end
    end

    assign o_valid    = !fifo_empty;
    assign o_data     = fifo_empty ? '0   : fifo_rd_data[BEAT_W-1:0];
    assign o_last     = fifo_empty ? 1'b0 : fifo_rd_data[BEAT_W + FLAG_LAST];
    assign o_abort    = fifo_empty ? 1'b0 : fifo_rd_data[BEAT_W + FLAG_ABORT];
    assign o_overflow = overflow_q;
    assign o_busy     = (state_q == RX);

endmodule

// File: tb/tb_spi_slave_rx_lanes.sv
// Self-checking bench: four instances (one per SPI mode, FEATURE_LENGTH=20)
// plus one FEATURE_LENGTH=40 / FIFO_DEPTH=2 instance for overflow.
// Expected beats are queued as frames are sent and popped on handshake.
module tb_spi_slave_rx_lanes;

    localparam int DW   = 8;
    localparam int NL   = 8;
    localparam int BW   = DW * NL;
    localparam int NI   = 5;
    localparam int HALF = 40;

    typedef struct {
        int            inst;
        logic [BW-1:0] data;
        logic          last;
        logic          abort;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          mosi = 1'b0;
    logic          sclk_a  [NI];
    logic          cs_a    [NI];
    logic          ready_a [NI];
    logic          valid_a [NI];
    logic          last_a  [NI];
    logic          abort_a [NI];
    logic          ovf_a   [NI];
    logic          busy_a  [NI];
    logic [BW-1:0] data_a  [NI];

    beat_t sb[$];
    int    tests   = 0;
    int    fails   = 0;
    int    ovf_cnt = 0;

    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_mode
            spi_slave_rx_lanes #(
                .DATA_WIDTH     (DW),
                .FEATURE_LENGTH (20),
                .LANES          (NL),
                .FIFO_DEPTH     (4),
                .CPOL           (gi / 2),
                .CPHA           (gi % 2)
            ) u_dut (
                .clk        (clk),
                .rst        (rst),
                .sclk       (sclk_a[gi]),
                .mosi       (mosi),
                .cs         (cs_a[gi]),
                .o_valid    (valid_a[gi]),
                .i_ready    (ready_a[gi]),
                .o_data     (data_a[gi]),
                .o_last     (last_a[gi]),
                .o_abort    (abort_a[gi]),
                .o_overflow (ovf_a[gi]),
                .o_busy     (busy_a[gi])
            );
        end
    endgenerate

    spi_slave_rx_lanes #(
        .DATA_WIDTH     (DW),
        .FEATURE_LENGTH (40),
        .LANES          (NL),
        .FIFO_DEPTH     (2),
        .CPOL           (0),
        .CPHA           (0)
    ) u_dut_ovf (
        .clk        (clk),
        .rst        (rst),
        .sclk       (sclk_a[4]),
        .mosi       (mosi),
        .cs         (cs_a[4]),
        .o_valid    (valid_a[4]),
        .i_ready    (ready_a[4]),
        .o_data     (data_a[4]),
        .o_last     (last_a[4]),
        .o_abort    (abort_a[4]),
        .o_overflow (ovf_a[4]),
        .o_busy     (busy_a[4])
    );

    task automatic chk(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [BW-1:0] pack(input int first, input int n);
        logic [BW-1:0] r;
        r = '0;
        for (int k = 0; k < n; k++) begin
            r[k*DW +: DW] = 8'(first + k);
        end
        return r;
    endfunction

    task automatic expect_beat(input int inst, input logic [BW-1:0] d, input logic last, input logic abort);
        beat_t b;
        b.inst  = inst;
        b.data  = d;
        b.last  = last;
        b.abort = abort;
        sb.push_back(b);
    endtask

    // Send the top nbits of b MSB-first in the mode of instance d.
    task automatic spi_bits(input int d, input logic [7:0] b, input int nbits);
        logic cpol;
        logic cpha;
        cpol = (d < 4) ? (d >= 2) : 1'b0;
        cpha = (d < 4) ? ((d % 2) == 1) : 1'b0;
        for (int i = 7; i > 7 - nbits; i--) begin
            if (!cpha) begin
                mosi = b[i];
                #HALF;
                sclk_a[d] = ~cpol;
                #HALF;
                sclk_a[d] = cpol;
            end else begin
                sclk_a[d] = ~cpol;
                mosi = b[i];
                #HALF;
                sclk_a[d] = cpol;
                #HALF;
            end
        end
    endtask

    // One CS window carrying n incrementing words starting at first.
    task automatic frame(input int d, input int first, input int n);
        cs_a[d] = 1'b0;
        #(2*HALF);
        for (int k = 0; k < n; k++) begin
            spi_bits(d, 8'(first + k), 8);
        end
        #(2*HALF);
        cs_a[d] = 1'b1;
        #(6*HALF);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("drain", sb.size(), 0);
        repeat (20) @(negedge clk);
    endtask

    // Scoreboard monitor: one line per accepted beat, compared to queue head.
    always @(negedge clk) begin : monitor
        beat_t e;
        if (!rst) begin
            for (int i = 0; i < NI; i++) begin
                if (valid_a[i] && ready_a[i]) begin
                    $display("[TB] beat inst=%0d data=%h last=%b abort=%b",
                             i, data_a[i], last_a[i], abort_a[i]);
                    if (sb.size() == 0) begin
                        chk("extra_beat", valid_a[i], 1'b0);
                    end else begin
                        e = sb.pop_front();
                        chk("beat_inst", i, e.inst);
                        chk($sformatf("beat_data_i%0d", i), data_a[i], e.data);
                        chk($sformatf("beat_last_i%0d", i), last_a[i], e.last);
                        chk($sformatf("beat_abort_i%0d", i), abort_a[i], e.abort);
                    end
                end
            end
            if (ovf_a[4]) ovf_cnt++;
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("[TB] FAIL watchdog timeout tests=%0d", tests);
        $fatal(1, "timeout");
    end

    initial begin : stim
        for (int i = 0; i < NI; i++) begin
            sclk_a[i]  = (i == 2 || i == 3);
            cs_a[i]    = 1'b1;
            ready_a[i] = (i != 4);
        end
        repeat (5) @(negedge clk);
        chk("rst_valid", valid_a[0], 1'b0);
        chk("rst_data",  data_a[0],  '0);
        chk("rst_last",  last_a[0],  1'b0);
        chk("rst_abort", abort_a[0], 1'b0);
        chk("rst_ovf",   ovf_a[0],   1'b0);
        chk("rst_busy",  busy_a[0],  1'b0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Full frame, mode 0
        expect_beat(0, pack(1, 8), 1'b0, 1'b0);
        expect_beat(0, pack(9, 8), 1'b0, 1'b0);
        expect_beat(0, pack(17, 4), 1'b1, 1'b0);
        frame(0, 1, 20);
        wait_drain();

        // Sign extremes in every mode (two words, then CS rise -> abort beat)
        for (int d = 0; d < 4; d++) begin
            expect_beat(d, {48'd0, 8'h7F, 8'h80}, 1'b1, 1'b1);
            cs_a[d] = 1'b0;
            #(2*HALF);
            spi_bits(d, 8'h80, 8);
            spi_bits(d, 8'h7F, 8);
            #(2*HALF);
            cs_a[d] = 1'b1;
            #(6*HALF);
            wait_drain();
        end

        // Abort after 10 words, then a full frame
        expect_beat(0, pack(1, 8), 1'b0, 1'b0);
        expect_beat(0, pack(9, 2), 1'b1, 1'b1);
        frame(0, 1, 10);
        wait_drain();
        expect_beat(0, pack(21, 8), 1'b0, 1'b0);
        expect_beat(0, pack(29, 8), 1'b0, 1'b0);
        expect_beat(0, pack(37, 4), 1'b1, 1'b0);
        frame(0, 21, 20);
        wait_drain();

        // Abort on a beat boundary, then an empty CS pulse
        expect_beat(0, pack(1, 8), 1'b0, 1'b0);
        expect_beat(0, '0, 1'b1, 1'b1);
        frame(0, 1, 8);
        wait_drain();
        frame(0, 1, 0);
        wait_drain();

        // Reset in the middle of word 5
        cs_a[0] = 1'b0;
        #(2*HALF);
        for (int k = 0; k < 4; k++) spi_bits(0, 8'(k + 1), 8);
        spi_bits(0, 8'h5A, 4);
        #(2*HALF);
        @(negedge clk);
        chk("busy_before_rst", busy_a[0], 1'b1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_valid", valid_a[0], 1'b0);
        chk("rst_mid_busy",  busy_a[0],  1'b0);
        rst = 1'b0;
        cs_a[0] = 1'b1;
        #(6*HALF);
        expect_beat(0, pack(1, 8), 1'b0, 1'b0);
        expect_beat(0, pack(9, 8), 1'b0, 1'b0);
        expect_beat(0, pack(17, 4), 1'b1, 1'b0);
        frame(0, 1, 20);
        wait_drain();

        // Overflow: depth-2 FIFO, consumer stalled for a 40-word frame
        ovf_cnt = 0;
        expect_beat(4, pack(1, 8), 1'b0, 1'b0);
        expect_beat(4, pack(9, 8), 1'b0, 1'b0);
        frame(4, 1, 40);
        repeat (20) @(negedge clk);
        chk("ovf_pulses", ovf_cnt, 3);
        chk("ovf_retained_valid", valid_a[4], 1'b1);
        ready_a[4] = 1'b1;
        wait_drain();
        chk("ovf_empty_after", valid_a[4], 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
